// File: rtl/apb_pkg.sv
// Shared types and elaboration helpers for the APB register completer.
package apb_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    DONE   = 2'd2
  } apb_state_e;

  localparam int WCNT_W = 4;

  // Byte-offset bits below the word index.
  function automatic int addr_lsb(input int data_width);
    return $clog2(data_width / 8);
  endfunction

  function automatic int idx_bits(input int reg_count);
    return (reg_count > 1) ? $clog2(reg_count) : 0;
  endfunction

  // Storage width for an index; never zero so ports stay legal.
  function automatic int idx_width(input int reg_count);
    return (idx_bits(reg_count) > 0) ? idx_bits(reg_count) : 1;
  endfunction

endpackage

// File: rtl/apb_reg_bank.sv
// Word register file with byte-strobe writes, read-only status mux and
// a one-cycle write pulse per register.
module apb_reg_bank
  import apb_pkg::*;
#(
  parameter int                    DATA_WIDTH = 32,
  parameter int                    REG_COUNT  = 4,
  parameter logic [REG_COUNT-1:0]  RO_MASK    = '0,
  parameter int                    IDX_W      = idx_width(REG_COUNT)
) (
  input  logic                            i_clk,
  input  logic                            i_rst_n,
  input  logic                            i_we,
  input  logic [IDX_W-1:0]                i_idx,
  input  logic [DATA_WIDTH-1:0]           i_wdata,
  input  logic [DATA_WIDTH/8-1:0]         i_strb,
  input  logic [REG_COUNT*DATA_WIDTH-1:0] i_status,
  output logic [DATA_WIDTH-1:0]           o_rdata,
  output logic [REG_COUNT*DATA_WIDTH-1:0] o_reg_out,
  output logic [REG_COUNT-1:0]            o_wr_pulse
);

  localparam int STRB_W = DATA_WIDTH / 8;

  logic [DATA_WIDTH-1:0] r_regs [REG_COUNT];
  logic [REG_COUNT-1:0]  r_wr_pulse;

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      // NOTE: these are individual flops, not a RAM macro, so a reset loop is
      // legal here and gives every control register its required zero value.
      for (int i = 0; i < REG_COUNT; i++) r_regs[i] <= '0;
      r_wr_pulse <= '0;
    end else begin
      // NOTE: non-blocking assignments keep every flop sampling pre-edge values,
      // so the default-clear of the pulse and the set below cannot race.
      r_wr_pulse <= '0;
      for (int i = 0; i < REG_COUNT; i++) begin
        if (i_we && (i_idx == IDX_W'(i))) begin
          for (int b = 0; b < STRB_W; b++) begin
            if (i_strb[b]) r_regs[i][b*8 +: 8] <= i_wdata[b*8 +: 8];
          end
          r_wr_pulse[i] <= 1'b1;
        end
      end
    end
  end

  always_comb begin
    // NOTE: assign a default before any conditional write so no path leaves
    // the output unassigned, which would otherwise infer a latch.
    o_rdata = '0;
    for (int i = 0; i < REG_COUNT; i++) begin
      if (i_idx == IDX_W'(i)) begin
        o_rdata = RO_MASK[i] ? i_status[i*DATA_WIDTH +: DATA_WIDTH] : r_regs[i];
      end
    end
  end

  for (genvar g = 0; g < REG_COUNT; g++) begin : g_reg_out
    assign o_reg_out[g*DATA_WIDTH +: DATA_WIDTH] = r_regs[g];
  end

  assign o_wr_pulse = r_wr_pulse;

endmodule

// File: rtl/apb_reg_completer.sv
// APB4 completer: setup/access FSM with programmable wait states, address
// decode with error response, and a byte-strobed register bank behind it.
module apb_reg_completer
  import apb_pkg::*;
#(
  parameter int                   ADDR_WIDTH  = 32,
  parameter int                   DATA_WIDTH  = 32,
  parameter int                   REG_COUNT   = 4,
  parameter int                   WAIT_STATES = 0,
  parameter logic [REG_COUNT-1:0] RO_MASK     = '0
) (
  input  logic                            s_apb_aclk,
  input  logic                            s_apb_aresetn,
  input  logic [ADDR_WIDTH-1:0]           s_apb_paddr,
  input  logic                            s_apb_psel,
  input  logic                            s_apb_penable,
  input  logic                            s_apb_pwrite,
  input  logic [DATA_WIDTH-1:0]           s_apb_pwdata,
  input  logic [DATA_WIDTH/8-1:0]         s_apb_pstrb,
  output logic [DATA_WIDTH-1:0]           s_apb_prdata,
  output logic                            s_apb_pready,
  output logic                            s_apb_pslverr,
  output logic [REG_COUNT*DATA_WIDTH-1:0] reg_out,
  input  logic [REG_COUNT*DATA_WIDTH-1:0] status_in,
  output logic [REG_COUNT-1:0]            reg_wr_pulse
);

  localparam int ADDR_LSB = addr_lsb(DATA_WIDTH);
  localparam int IDX_BITS = idx_bits(REG_COUNT);
  localparam int IDX_W    = idx_width(REG_COUNT);

  apb_state_e          r_state;
  logic [WCNT_W-1:0]   r_wcnt;

  logic                w_setup;
  logic                w_pready;
  logic                w_misaligned;
  logic                w_high_bits;
  logic                w_in_range;
  logic                w_ro;
  logic                w_err;
  logic                w_we;
  logic [IDX_W-1:0]    w_idx;
  logic [DATA_WIDTH-1:0] w_rdata;

  assign w_setup = s_apb_psel && !s_apb_penable;

  // Reset is synchronous, so the current-cycle reset level gates completion:
  // a transfer caught by reset never reports ready and never commits.
  assign w_pready = s_apb_aresetn && (r_state == ACCESS) && s_apb_psel &&
                    s_apb_penable && (r_wcnt == '0);

  always_ff @(posedge s_apb_aclk) begin
    if (!s_apb_aresetn) begin
      r_state <= IDLE;
      r_wcnt  <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_setup) begin
            r_wcnt  <= WCNT_W'(WAIT_STATES);
            r_state <= ACCESS;
          end
        end
        ACCESS: begin
          if (!s_apb_psel) begin
            r_state <= IDLE;
          end else if (s_apb_penable) begin
            if (r_wcnt == '0) r_state <= DONE;
            else              r_wcnt  <= r_wcnt - 1'b1;
          end
        end
        DONE: begin
          // A setup phase arriving right after completion is taken directly.
          if (w_setup) begin
            r_wcnt  <= WCNT_W'(WAIT_STATES);
            r_state <= ACCESS;
          end else begin
            r_state <= IDLE;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  // Split the byte address into offset, index and must-be-zero upper bits.
  always_comb begin
    w_misaligned = 1'b0;
    w_high_bits  = 1'b0;
    w_idx        = '0;
    for (int i = 0; i < ADDR_WIDTH; i++) begin
      if (i < ADDR_LSB)                  w_misaligned = w_misaligned | s_apb_paddr[i];
      else if (i >= ADDR_LSB + IDX_BITS) w_high_bits  = w_high_bits  | s_apb_paddr[i];
    end
    for (int i = 0; i < IDX_BITS; i++) w_idx[i] = s_apb_paddr[ADDR_LSB + i];
  end

  always_comb begin
    w_ro = 1'b0;
    for (int i = 0; i < REG_COUNT; i++) begin
      if (w_idx == IDX_W'(i)) w_ro = RO_MASK[i];
    end
  end

  assign w_in_range = (int'(w_idx) < REG_COUNT);
  assign w_err      = w_misaligned || w_high_bits || !w_in_range ||
                      (s_apb_pwrite && w_ro);
  assign w_we       = w_pready && s_apb_pwrite && !w_err;

  apb_reg_bank #(
    .DATA_WIDTH (DATA_WIDTH),
    .REG_COUNT  (REG_COUNT),
    .RO_MASK    (RO_MASK),
    .IDX_W      (IDX_W)
  ) u_bank (
    .i_clk      (s_apb_aclk),
    .i_rst_n    (s_apb_aresetn),
    .i_we       (w_we),
    .i_idx      (w_idx),
    .i_wdata    (s_apb_pwdata),
    .i_strb     (s_apb_pstrb),
    .i_status   (status_in),
    .o_rdata    (w_rdata),
    .o_reg_out  (reg_out),
    .o_wr_pulse (reg_wr_pulse)
  );

  assign s_apb_pready  = w_pready;
  assign s_apb_pslverr = w_pready && w_err;
  assign s_apb_prdata  = (w_pready && !s_apb_pwrite && !w_err) ? w_rdata : '0;

endmodule

// File: tb/tb_apb_reg_completer.sv
// Bench for apb_reg_completer: two instances (0 and 3 wait states) checked
// against a word-array model, a vector table, hand sequences and random traffic.
module tb_apb_reg_completer;

  localparam logic [3:0] RO = 4'b1000;

  logic         clk = 1'b0;
  logic         rst_n;
  logic [31:0]  paddr   [2];
  logic         psel    [2];
  logic         penable [2];
  logic         pwrite  [2];
  logic [31:0]  pwdata  [2];
  logic [3:0]   pstrb   [2];
  logic [31:0]  prdata  [2];
  logic         pready  [2];
  logic         pslverr [2];
  logic [127:0] reg_out [2];
  logic [3:0]   wr_pulse[2];
  logic [127:0] status_in;

  logic [31:0]  mdl [2][4];
  int           n_checks = 0;
  int           n_fail   = 0;

  always #5 clk = ~clk;

  apb_reg_completer #(
    .ADDR_WIDTH(32), .DATA_WIDTH(32), .REG_COUNT(4), .WAIT_STATES(0), .RO_MASK(RO)
  ) u_dut0 (
    .s_apb_aclk(clk), .s_apb_aresetn(rst_n), .s_apb_paddr(paddr[0]),
    .s_apb_psel(psel[0]), .s_apb_penable(penable[0]), .s_apb_pwrite(pwrite[0]),
    .s_apb_pwdata(pwdata[0]), .s_apb_pstrb(pstrb[0]), .s_apb_prdata(prdata[0]),
    .s_apb_pready(pready[0]), .s_apb_pslverr(pslverr[0]), .reg_out(reg_out[0]),
    .status_in(status_in), .reg_wr_pulse(wr_pulse[0])
  );

  apb_reg_completer #(
    .ADDR_WIDTH(32), .DATA_WIDTH(32), .REG_COUNT(4), .WAIT_STATES(3), .RO_MASK(RO)
  ) u_dut1 (
    .s_apb_aclk(clk), .s_apb_aresetn(rst_n), .s_apb_paddr(paddr[1]),
    .s_apb_psel(psel[1]), .s_apb_penable(penable[1]), .s_apb_pwrite(pwrite[1]),
    .s_apb_pwdata(pwdata[1]), .s_apb_pstrb(pstrb[1]), .s_apb_prdata(prdata[1]),
    .s_apb_pready(pready[1]), .s_apb_pslverr(pslverr[1]), .reg_out(reg_out[1]),
    .status_in(status_in), .reg_wr_pulse(wr_pulse[1])
  );

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic int wait_states(input int d);
    return (d == 1) ? 3 : 0;
  endfunction

  function automatic bit mdl_err(input bit wr, input logic [31:0] addr);
    if (addr % 4 != 0) return 1'b1;
    if (addr / 4 >= 4) return 1'b1;
    return wr && RO[addr / 4];
  endfunction

  function automatic logic [31:0] mdl_read(input int d, input int idx);
    return RO[idx] ? status_in[idx*32 +: 32] : mdl[d][idx];
  endfunction

  function automatic logic [127:0] mdl_regout(input int d);
    logic [127:0] r;
    for (int i = 0; i < 4; i++) r[i*32 +: 32] = mdl[d][i];
    return r;
  endfunction

  task automatic mdl_clear();
    for (int d = 0; d < 2; d++) for (int i = 0; i < 4; i++) mdl[d][i] = '0;
  endtask

  task automatic bus_idle(input int d);
    psel[d] = 1'b0; penable[d] = 1'b0; pwrite[d] = 1'b0;
    paddr[d] = '0; pwdata[d] = '0; pstrb[d] = '0;
  endtask

  // Advance n cycles; returns #1 after a rising edge.
  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Full transfer. Entered and left at #1 after a rising edge, so a following
  // call puts its setup phase into the cycle right after completion.
  task automatic xfer(input int d, input bit wr, input logic [31:0] addr,
                      input logic [31:0] wdata, input logic [3:0] strb,
                      output logic [31:0] rd, output bit err);
    bit          exp_err;
    logic [31:0] exp_rd;
    logic [3:0]  exp_pulse;
    int          waits;
    bit          done;
    exp_err   = mdl_err(wr, addr);
    exp_rd    = (!wr && !exp_err) ? mdl_read(d, addr / 4) : 32'h0;
    exp_pulse = (wr && !exp_err) ? 4'(1 << (addr / 4)) : 4'h0;
    rd = '0; err = 1'b0;
    psel[d] = 1'b1; penable[d] = 1'b0; pwrite[d] = wr;
    paddr[d] = addr; pwdata[d] = wdata; pstrb[d] = strb;
    @(negedge clk);
    check("setup_pready", pready[d], 1'b0);
    @(posedge clk); #1;
    penable[d] = 1'b1;
    waits = 0; done = 1'b0;
    while (!done && waits < 40) begin
      @(negedge clk);
      if (pready[d]) begin
        done = 1'b1; rd = prdata[d]; err = pslverr[d];
      end else begin
        waits++;
      end
    end
    check("pready_seen", done, 1'b1);
    check($sformatf("wait_cycles_d%0d", d), waits, wait_states(d));
    check("pslverr", err, exp_err);
    check("prdata", rd, exp_rd);
    @(posedge clk); #1;
    if (wr && !exp_err)
      for (int b = 0; b < 4; b++) if (strb[b]) mdl[d][addr/4][b*8 +: 8] = wdata[b*8 +: 8];
    check("wr_pulse", wr_pulse[d], exp_pulse);
    check("reg_out", reg_out[d], mdl_regout(d));
    bus_idle(d);
  endtask

  typedef struct {
    int          d;
    bit          wr;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  strb;
    logic [31:0] exp_rd;
    bit          exp_err;
  } vec_t;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t        vecs[$];
    logic [31:0] rd;
    bit          er;

    vecs.push_back('{0, 1'b0, 32'h0,        32'h0,        4'h0, 32'h0000_0000, 1'b0});
    vecs.push_back('{0, 1'b0, 32'h4,        32'h0,        4'h0, 32'h0000_0000, 1'b0});
    vecs.push_back('{0, 1'b0, 32'h8,        32'h0,        4'h0, 32'h0000_0000, 1'b0});
    vecs.push_back('{0, 1'b0, 32'hC,        32'h0,        4'h0, 32'hCAFE_0001, 1'b0});
    vecs.push_back('{0, 1'b1, 32'h4,        32'hDEAD_BEEF, 4'hF, 32'h0000_0000, 1'b0});
    vecs.push_back('{0, 1'b1, 32'h4,        32'h1122_3344, 4'h5, 32'h0000_0000, 1'b0});
    vecs.push_back('{0, 1'b0, 32'h4,        32'h0,        4'h0, 32'hDE22_BE44, 1'b0});
    vecs.push_back('{0, 1'b0, 32'h10,       32'h0,        4'h0, 32'h0000_0000, 1'b1});
    vecs.push_back('{0, 1'b0, 32'h8000_0004, 32'h0,       4'h0, 32'h0000_0000, 1'b1});
    vecs.push_back('{0, 1'b1, 32'h2,        32'hFFFF_FFFF, 4'hF, 32'h0000_0000, 1'b1});
    vecs.push_back('{0, 1'b0, 32'h0,        32'h0,        4'h0, 32'h0000_0000, 1'b0});
    vecs.push_back('{0, 1'b1, 32'hC,        32'h1234_5678, 4'hF, 32'h0000_0000, 1'b1});
    vecs.push_back('{0, 1'b0, 32'hC,        32'h0,        4'h0, 32'hCAFE_0001, 1'b0});
    vecs.push_back('{1, 1'b1, 32'h8,        32'hA5A5_0F0F, 4'hF, 32'h0000_0000, 1'b0});
    vecs.push_back('{1, 1'b0, 32'h8,        32'h0,        4'h0, 32'hA5A5_0F0F, 1'b0});
    vecs.push_back('{1, 1'b1, 32'h8,        32'hFFFF_FFFF, 4'h0, 32'h0000_0000, 1'b0});
    vecs.push_back('{1, 1'b0, 32'h8,        32'h0,        4'h0, 32'hA5A5_0F0F, 1'b0});

    mdl_clear();
    status_in = {32'hCAFE_0001, 32'h3333_3333, 32'h2222_2222, 32'h1111_1111};
    bus_idle(0); bus_idle(1);
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    for (int d = 0; d < 2; d++) begin
      check("rst_pready", pready[d], 1'b0);
      check("rst_pslverr", pslverr[d], 1'b0);
      check("rst_prdata", prdata[d], 32'h0);
      check("rst_pulse", wr_pulse[d], 4'h0);
      check("rst_reg_out", reg_out[d], 128'h0);
    end
    @(posedge clk); #1;
    rst_n = 1'b1;
    idle(1);

    for (int i = 0; i < vecs.size(); i++) begin
      xfer(vecs[i].d, vecs[i].wr, vecs[i].addr, vecs[i].wdata, vecs[i].strb, rd, er);
      check($sformatf("vec%0d_rdata", i), rd, vecs[i].exp_rd);
      check($sformatf("vec%0d_err", i), er, vecs[i].exp_err);
    end

    // Pulse lasts exactly one cycle.
    xfer(0, 1'b1, 32'h8, 32'h0BAD_F00D, 4'hF, rd, er);
    idle(1);
    check("pulse_one_cycle", wr_pulse[0], 4'h0);

    // Back-to-back: read setup lands in the cycle after write completion.
    xfer(0, 1'b1, 32'h0, 32'h0000_005A, 4'hF, rd, er);
    xfer(0, 1'b0, 32'h0, 32'h0,         4'h0, rd, er);
    check("b2b_read_after_write", rd, 32'h0000_005A);
    idle(1);

    // Abort: drop psel during a wait state of a write.
    psel[1] = 1'b1; penable[1] = 1'b0; pwrite[1] = 1'b1;
    paddr[1] = 32'h8; pwdata[1] = 32'hFFFF_FFFF; pstrb[1] = 4'hF;
    idle(1);
    penable[1] = 1'b1;
    @(negedge clk);
    check("abort_wait_pready", pready[1], 1'b0);
    @(posedge clk); #1;
    bus_idle(1);
    repeat (3) begin
      @(negedge clk);
      check("abort_pulse", wr_pulse[1], 4'h0);
      check("abort_reg_out", reg_out[1], mdl_regout(1));
    end
    idle(1);
    xfer(1, 1'b0, 32'h8, 32'h0, 4'h0, rd, er);
    check("abort_reg2_kept", rd, 32'hA5A5_0F0F);

    // Reset in the cycle a write of reg 1 would complete.
    psel[1] = 1'b1; penable[1] = 1'b0; pwrite[1] = 1'b1;
    paddr[1] = 32'h4; pwdata[1] = 32'h0000_0077; pstrb[1] = 4'hF;
    idle(1);
    penable[1] = 1'b1;
    idle(3);
    rst_n = 1'b0;
    @(negedge clk);
    check("rst_mid_pready", pready[1], 1'b0);
    @(posedge clk); #1;
    bus_idle(1);
    mdl_clear();
    @(negedge clk);
    check("rst_mid_pulse", wr_pulse[1], 4'h0);
    check("rst_mid_reg_out", reg_out[1], 128'h0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    idle(1);
    xfer(1, 1'b0, 32'h4, 32'h0, 4'h0, rd, er);
    check("rst_mid_reg1_zero", rd, 32'h0);

    // Random traffic against the model.
    for (int n = 0; n < 300; n++) begin
      int          d;
      bit          wr;
      logic [31:0] addr;
      if (n % 25 == 0) status_in = {$urandom, $urandom, $urandom, $urandom};
      d    = $urandom_range(0, 1);
      wr   = 1'($urandom_range(0, 1));
      addr = 32'($urandom_range(0, 5) * 4);
      if ($urandom_range(0, 7) == 0) addr = addr + 32'($urandom_range(1, 3));
      if ($urandom_range(0, 15) == 0) addr = addr | 32'h0001_0000;
      xfer(d, wr, addr, $urandom, 4'($urandom_range(0, 15)), rd, er);
      if ($urandom_range(0, 3) == 0) idle(1);
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/apb_reg_completer.md
Name: apb_reg_completer

Overview:
- Parametrised APB4 completer that replaces the tie-off stub with a working register bank.
- Provides REG_COUNT word registers: read/write control registers and read-only status registers.
- Adds programmable wait states, byte strobes and error response for bad accesses.
- Sits between the PS-side APB bridge and PL fabric logic, one instance per peripheral.

Parameters:
- ADDR_WIDTH, 32, APB address width.
- DATA_WIDTH, 32, data width; must be 8, 16 or 32.
- REG_COUNT, 4, number of word registers; must be 1..256.
- WAIT_STATES, 0, access-phase cycles with pready low before completion; must be 0..15.
- RO_MASK, {REG_COUNT{1'b0}}, bit i=1 makes register i read-only (reads status_in slice i).

Ports:
- s_apb_aclk  in  1  clock.
- s_apb_aresetn  in  1  reset.
- s_apb_paddr  in  ADDR_WIDTH  byte address.
- s_apb_psel  in  1  select.
- s_apb_penable  in  1  access phase.
- s_apb_pwrite  in  1  1=write.
- s_apb_pwdata  in  DATA_WIDTH  write data.
- s_apb_pstrb  in  DATA_WIDTH/8  byte write strobes.
- s_apb_prdata  out  DATA_WIDTH  read data.
- s_apb_pready  out  1  transfer complete.
- s_apb_pslverr  out  1  error, valid only with pready.
- reg_out  out  REG_COUNT*DATA_WIDTH  control register contents; register i occupies slice [i*DATA_WIDTH +: DATA_WIDTH].
- status_in  in  REG_COUNT*DATA_WIDTH  status values; slices used only where RO_MASK=1.
- reg_wr_pulse  out  REG_COUNT  one-cycle strobe on each successful write to register i.

Behaviour:
- Clocking and reset:
  - Single clock s_apb_aclk.
  - Reset s_apb_aresetn is synchronous, active-low.
  - While reset is sampled low: all control registers = 0, FSM = IDLE, wait counter = 0.
  - Outputs in reset: pready=0, pslverr=0, prdata=0, reg_wr_pulse=0.
- Decode:
  - ADDR_LSB = log2(DATA_WIDTH/8).
  - idx = paddr[ADDR_LSB +: clog2(REG_COUNT)].
  - Error conditions: paddr[ADDR_LSB-1:0] != 0 (misaligned); any paddr bit above the idx field set; idx >= REG_COUNT; write with RO_MASK[idx]=1.
- FSM states IDLE, ACCESS, DONE; registered counter wcnt.
  - IDLE: when psel=1 and penable=0 (setup), load wcnt = WAIT_STATES, go to ACCESS.
  - ACCESS: while psel & penable and wcnt != 0, decrement wcnt with pready=0.
  - ACCESS completion: when wcnt == 0, pready=1 combinationally from state/wcnt, and the transfer completes this cycle. Go to DONE.
  - ACCESS abort: if psel drops, return to IDLE with no side effects.
  - DONE: one cycle, pready=0, then IDLE. If the next setup phase arrives in this cycle, it is accepted (load wcnt, go to ACCESS).
  - Latency with WAIT_STATES=0: one setup plus one access cycle, the APB minimum. Each wait state adds exactly one cycle.
- Write completion (pready cycle, no error):
  - For each byte b with pstrb[b]=1, reg[idx] byte b = pwdata byte b.
  - reg_wr_pulse[idx] is asserted the following cycle, for one cycle.
  - pstrb=0 is a legal no-op write: reg_wr_pulse still asserted, pslverr=0.
- Error completion: pslverr=1 with pready; no register change; no pulse.
- Read completion:
  - prdata = reg[idx], or status_in slice idx if RO_MASK[idx]=1, sampled in the pready cycle.
  - prdata = 0 on error and outside pready cycles.
  - pstrb is ignored on reads.
- Read-after-write to the same register in back-to-back transfers returns the new value.
- reg_out reflects the registered value the cycle after the write completes.
- Reset asserted mid-transfer: transfer is dropped, no write is committed, pready stays 0. The requester must restart the transfer.

Decomposition:
- Shared package apb_pkg:
  - FSM state typedef (IDLE/ACCESS/DONE).
  - ADDR_LSB function of DATA_WIDTH.
  - Index-width helper.
- One sub-module, apb_reg_bank:
  - Storage, byte-strobe writes, RO mux, write-pulse generation.
  - Inputs: we, idx, wdata, strb.
  - Outputs: rdata, reg_out, reg_wr_pulse.
  - The top level holds the FSM, wait counter and decode/error logic.

Test Plan:
- Reset then read: WAIT_STATES=0, read each reg 0..3 -> prdata=0x0000_0000, pready high in 2nd cycle, pslverr=0.
- Byte-strobe write: write 0xDEADBEEF to 0x4 with pstrb=4'b1111, then 0x11223344 with pstrb=4'b0101 -> read 0x4 returns 0xDE22BE44; reg_wr_pulse[1] high one cycle per write.
- Wait states: WAIT_STATES=3, write reg 2 -> pready low for 3 access cycles and high on the 4th; reg_out slice 2 updates the cycle after.
- Errors:
  - Read 0x10 (REG_COUNT=4) -> pslverr=1, prdata=0.
  - Write 0x2 (misaligned) -> pslverr=1, no register change.
  - Write to RO reg (RO_MASK=4'b1000, 0xC) -> pslverr=1, no pulse.
  - Read of that RO reg with status_in slice 3=0xCAFE0001 -> 0xCAFE0001.
- Back-to-back and abort: write reg 0 = 0x5A, then immediately read reg 0 (setup in DONE cycle) -> 0x5A. Separately, drop psel during a wait state -> no write, no pulse.
- Reset mid-transfer: assert aresetn=0 during the ACCESS wait of a write to reg 1 -> reg 1 stays 0, pready=0. After release, a new read of reg 1 completes normally returning 0.
